onehot_split_dispatch: RTL and testbench

- Inverse of the one-hot AND-OR combiner used on the datapath select paths.
- Takes one WIDTH-bit source word plus a 3-bit one-hot (or multi-hot) destination select {c,d,e}.
- Delivers the word into three registered output slots, each with its own valid/ready handshake.
- Sits between the decode-side select generation and three independent consumers. Supports multicast, back-pressure and drop accounting.

---
 rtl/onehot_split_dispatch.sv | 57 +++++
 tb/tb_onehot_split_dispatch.sv | 86 ++++++++
 2 files changed

// File: rtl/onehot_split_dispatch.sv
// onehot_split_dispatch: routes one source word into up to three registered valid/ready slots by one/multi-hot select, with drop counting and a sticky protocol-error flag (strict single-hot mode under ONEHOT_SPLIT_STRICT_EN); ports: clk, rst, in_valid/in_ready/in_data/in_sel source side, out_valid/out_ready/out_data0..2 consumer side, drop_cnt, err
module onehot_split_dispatch #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err
);
  logic [2:0]       slot_free, load, pend_sel;
  logic             multi, accept, drop, pend, unstable;
  logic [WIDTH-1:0] pend_data;
  assign slot_free = ~out_valid | out_ready;
`ifdef ONEHOT_SPLIT_STRICT_EN
  assign multi = (in_sel & (in_sel - 3'd1)) != 3'b000;
`else
  assign multi = 1'b0;
`endif
  assign in_ready = !rst && (multi || (in_sel & ~slot_free) == 3'b000);
  assign accept   = in_valid && in_ready;
  assign load     = (accept && !multi) ? in_sel : 3'b000;
  assign drop     = accept && (multi || in_sel == 3'b000);
  assign unstable = pend && in_valid && (in_data != pend_data || in_sel != pend_sel);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 3'b000;
      out_data0 <= '0;
      out_data1 <= '0;
      out_data2 <= '0;
      drop_cnt  <= '0;
      err       <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
      pend_sel  <= 3'b000;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
      if (load[0]) out_data0 <= in_data;
      if (load[1]) out_data1 <= in_data;
      if (load[2]) out_data2 <= in_data;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (unstable || (accept && multi)) err <= 1'b1;
      pend      <= in_valid && !in_ready;
      pend_data <= in_data;
      pend_sel  <= in_sel;
    end
  end
endmodule

// File: tb/tb_onehot_split_dispatch.sv
// tb_onehot_split_dispatch: table-driven directed check of onehot_split_dispatch (WIDTH=2, CNT_W=2)
module tb_onehot_split_dispatch;
  logic       clk = 0, rst = 1, in_valid = 0, in_ready, err;
  logic [1:0] in_data = 0, out_data0, out_data1, out_data2, drop_cnt;
  logic [2:0] in_sel = 0, out_valid, out_ready = 0;
  int total = 0, passed = 0;
  typedef struct {
    logic       rst, iv;
    logic [1:0] data;
    logic [2:0] sel, ordy;
    logic       ir;
    logic [2:0] ov;
    logic [1:0] d0, d1, d2, drop;
    logic       err;
  } vec_t;
  vec_t vecs[21];
  onehot_split_dispatch #(.WIDTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data0(out_data0),
    .out_data1(out_data1), .out_data2(out_data2), .drop_cnt(drop_cnt), .err(err)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic iv, logic [1:0] dt, logic [2:0] s, logic [2:0] o,
                              logic ir, logic [2:0] ov, logic [1:0] d0, logic [1:0] d1,
                              logic [1:0] d2, logic [1:0] dr, logic e);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = dt; v.sel = s; v.ordy = o; v.ir = ir; v.ov = ov;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.drop = dr; v.err = e;
    return v;
  endfunction
  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL step %0d %s: got %0h expected %0h", idx, name, act, exp);
  endtask
  task automatic step(int idx, vec_t v);
    @(negedge clk);
    rst = v.rst; in_valid = v.iv; in_data = v.data; in_sel = v.sel; out_ready = v.ordy;
    #1 chk("in_ready", idx, {7'd0, in_ready}, {7'd0, v.ir});
    @(posedge clk);
    #1;
    chk("out_valid", idx, {5'd0, out_valid}, {5'd0, v.ov});
    chk("out_data0", idx, {6'd0, out_data0}, {6'd0, v.d0});
    chk("out_data1", idx, {6'd0, out_data1}, {6'd0, v.d1});
    chk("out_data2", idx, {6'd0, out_data2}, {6'd0, v.d2});
    chk("drop_cnt", idx, {6'd0, drop_cnt}, {6'd0, v.drop});
    chk("err", idx, {7'd0, err}, {7'd0, v.err});
  endtask
  initial begin
    //            rst iv data  sel     ordy    ir  ov      d0 d1 d2 drop err
    vecs[0]  = mk(1, 0, 2'd0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2'd2, 3'b010, 3'b111, 1, 3'b010, 0, 2, 0, 0, 0);
    vecs[2]  = mk(0, 0, 2'd2, 3'b000, 3'b111, 1, 3'b000, 0, 2, 0, 0, 0);
    vecs[3]  = mk(0, 1, 2'd1, 3'b001, 3'b000, 1, 3'b001, 1, 2, 0, 0, 0);
    vecs[4]  = mk(0, 1, 2'd3, 3'b001, 3'b000, 0, 3'b001, 1, 2, 0, 0, 0);
    vecs[5]  = mk(0, 1, 2'd3, 3'b001, 3'b001, 1, 3'b001, 3, 2, 0, 0, 0);
    vecs[6]  = mk(0, 0, 2'd3, 3'b000, 3'b111, 1, 3'b000, 3, 2, 0, 0, 0);
    vecs[7]  = mk(0, 1, 2'd1, 3'b000, 3'b111, 1, 3'b000, 3, 2, 0, 1, 0);
    vecs[8]  = mk(0, 1, 2'd2, 3'b000, 3'b111, 1, 3'b000, 3, 2, 0, 2, 0);
    vecs[9]  = mk(0, 1, 2'd3, 3'b000, 3'b000, 1, 3'b000, 3, 2, 0, 3, 0);
    vecs[10] = mk(0, 1, 2'd0, 3'b000, 3'b111, 1, 3'b000, 3, 2, 0, 3, 0);
    vecs[11] = mk(0, 1, 2'd1, 3'b000, 3'b111, 1, 3'b000, 3, 2, 0, 3, 0);
    vecs[12] = mk(0, 1, 2'd1, 3'b001, 3'b000, 1, 3'b001, 1, 2, 0, 3, 0);
    vecs[13] = mk(0, 1, 2'd2, 3'b001, 3'b000, 0, 3'b001, 1, 2, 0, 3, 0);
    vecs[14] = mk(0, 1, 2'd3, 3'b001, 3'b000, 0, 3'b001, 1, 2, 0, 3, 1);
    vecs[15] = mk(0, 0, 2'd0, 3'b000, 3'b001, 1, 3'b000, 1, 2, 0, 3, 1);
    vecs[16] = mk(0, 1, 2'd2, 3'b010, 3'b111, 1, 3'b010, 1, 2, 0, 3, 1);
    vecs[17] = mk(0, 1, 2'd1, 3'b100, 3'b000, 1, 3'b110, 1, 2, 1, 3, 1);
    vecs[18] = mk(0, 1, 2'd3, 3'b001, 3'b000, 1, 3'b111, 3, 2, 1, 3, 1);
    vecs[19] = mk(1, 1, 2'd2, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 2'd0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) step(i, vecs[i]);
`ifdef ONEHOT_SPLIT_STRICT_EN
    step(100, mk(0, 1, 2'd3, 3'b011, 3'b000, 1, 3'b000, 0, 0, 0, 1, 1));
    step(101, mk(0, 1, 2'd2, 3'b100, 3'b000, 1, 3'b100, 0, 0, 2, 1, 1));
    step(102, mk(0, 1, 2'd1, 3'b101, 3'b000, 1, 3'b100, 0, 0, 2, 2, 1));
`else
    step(100, mk(0, 1, 2'd2, 3'b100, 3'b000, 1, 3'b100, 0, 0, 2, 0, 0));
    step(101, mk(0, 1, 2'd3, 3'b101, 3'b000, 0, 3'b100, 0, 0, 2, 0, 0));
    step(102, mk(0, 1, 2'd3, 3'b101, 3'b100, 1, 3'b101, 3, 0, 3, 0, 0));
    step(103, mk(0, 1, 2'd1, 3'b111, 3'b111, 1, 3'b111, 1, 1, 1, 0, 0));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
